// File: rtl/phase_sweep_gen_if.sv
// Stream interface for phase_sweep_gen.
//   m_tvalid : sample valid (producer -> consumer)
//   m_tready : consumer ready (consumer -> producer)
//   m_tdata  : NUM_CH packed phase words, channel 0 in the low W bits
//   m_wrap   : per-channel wrap flag travelling with the sample
interface phase_sweep_gen_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 16
);
  logic                  m_tvalid;
  logic                  m_tready;
  logic [NUM_CH*W-1:0]   m_tdata;
  logic [NUM_CH-1:0]     m_wrap;

  modport master (output m_tvalid, output m_tdata, output m_wrap, input m_tready);
  modport slave  (input m_tvalid, input m_tdata, input m_wrap, output m_tready);
endinterface

// File: rtl/phase_sweep_gen.sv
// Multi-channel phase-sweep generator for CORDIC sin/cos phase inputs.
// Each channel holds a runtime-programmable signed increment and phase
// accumulator; phases wrap symmetrically at +/-PI_POS. A divider paces
// samples and the output is a valid/ready stream with backpressure.
// Ports:
//   CLK, RST  : clock and synchronous active-high reset
//   en        : sweep enable (divider and accumulators hold while low)
//   cfg_we    : configuration write strobe
//   cfg_sel   : 0 = write increment, 1 = write phase accumulator
//   cfg_ch    : target channel (out-of-range channels are ignored)
//   cfg_data  : signed value, clamped to [-PI_POS, PI_POS] before storing
//   m         : stream master (m_tvalid, m_tready, m_tdata, m_wrap)
module phase_sweep_gen #(
  parameter int                    NUM_CH = 2,
  parameter int                    W      = 16,
  parameter logic signed [W-1:0]   PI_POS = 16'sh6488,
  parameter int                    DIV    = 1,
  parameter int                    CHW    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic signed [W-1:0]  cfg_data,
  phase_sweep_gen_if.master    m
);

  // Two guard bits keep acc+inc exact for any pair of in-range values.
  localparam int                   SW         = W + 2;
  localparam int                   CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]        CNT_LAST   = CW'(DIV - 1);
  localparam logic [CHW:0]         NUM_CH_W   = (CHW + 1)'(NUM_CH);
  localparam logic signed [SW-1:0] PI_EXT     = {{2{PI_POS[W-1]}}, PI_POS};
  localparam logic signed [SW-1:0] NEG_PI_EXT = -PI_EXT;
  localparam logic signed [SW-1:0] TWO_PI     = PI_EXT + PI_EXT;

  // Saturate a configuration value into the legal phase range.
  function automatic logic signed [W-1:0] clamp_phase(input logic signed [W-1:0] d);
    logic signed [W-1:0] r;
    if (d > PI_POS) begin
      r = PI_POS;
    end else if (d < -PI_POS) begin
      r = -PI_POS;
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic signed [W-1:0]  acc_r     [NUM_CH];
  logic signed [W-1:0]  inc_r     [NUM_CH];
  logic signed [W-1:0]  acc_d_s   [NUM_CH];
  logic signed [SW-1:0] sum_s     [NUM_CH];
  logic [NUM_CH-1:0]    wrap_s;
  logic [NUM_CH-1:0]    ph_we_s;
  logic [NUM_CH-1:0]    inc_we_s;
  logic [NUM_CH*W-1:0]  tdata_d_s;
  logic signed [W-1:0]  clamped_s;
  logic                 ch_ok_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_d_s;
  logic                 tick_s;
  logic                 adv_s;
  logic                 tvalid_r;
  logic [NUM_CH*W-1:0]  tdata_r;
  logic [NUM_CH-1:0]    wrap_r;

  assign m.m_tvalid = tvalid_r;
  assign m.m_tdata  = tdata_r;
  assign m.m_wrap   = wrap_r;

  // Advance only when the divider ticks and the output slot is free or draining.
  always_comb begin
    tick_s = (cnt_r == CNT_LAST);
    adv_s  = tick_s & en & (~tvalid_r | m.m_tready);
  end

  // Divider next state: a blocked tick holds at the last count until it advances.
  always_comb begin
    cnt_d_s = cnt_r;
    if (en) begin
      if (tick_s) begin
        cnt_d_s = adv_s ? {CW{1'b0}} : cnt_r;
      end else begin
        cnt_d_s = cnt_r + CW'(1'b1);
      end
    end else begin
      cnt_d_s = cnt_r;
    end
  end

  // Configuration decode: per-channel write enables for increment and phase.
  always_comb begin
    clamped_s = clamp_phase(cfg_data);
    ch_ok_s   = ({1'b0, cfg_ch} < NUM_CH_W);
    ph_we_s   = {NUM_CH{1'b0}};
    inc_we_s  = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ph_we_s[i]  = cfg_we & cfg_sel & ch_ok_s & (cfg_ch == CHW'(i));
      inc_we_s[i] = cfg_we & ~cfg_sel & ch_ok_s & (cfg_ch == CHW'(i));
    end
  end

  // Accumulator next state with symmetric wrap; a phase write wins over the advance.
  always_comb begin
    wrap_s    = {NUM_CH{1'b0}};
    tdata_d_s = {(NUM_CH*W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      tdata_d_s[i*W +: W] = acc_r[i];
      sum_s[i]   = {{2{acc_r[i][W-1]}}, acc_r[i]} + {{2{inc_r[i][W-1]}}, inc_r[i]};
      acc_d_s[i] = acc_r[i];
      if (ph_we_s[i]) begin
        acc_d_s[i] = clamped_s;
        wrap_s[i]  = 1'b0;
      end else if (adv_s) begin
        if (sum_s[i] > PI_EXT) begin
          acc_d_s[i] = W'(sum_s[i] - TWO_PI);
          wrap_s[i]  = 1'b1;
        end else if (sum_s[i] < NEG_PI_EXT) begin
          acc_d_s[i] = W'(sum_s[i] + TWO_PI);
          wrap_s[i]  = 1'b1;
        end else begin
          acc_d_s[i] = W'(sum_s[i]);
          wrap_s[i]  = 1'b0;
        end
      end else begin
        acc_d_s[i] = acc_r[i];
        wrap_s[i]  = 1'b0;
      end
    end
  end

  // Channel state and divider registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i] <= {W{1'b0}};
        inc_r[i] <= {W{1'b0}};
      end
    end else begin
      cnt_r <= cnt_d_s;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i] <= acc_d_s[i];
        if (inc_we_s[i]) begin
          inc_r[i] <= clamped_s;
        end
      end
    end
  end

  // Output register: load on advance, retire on handshake, hold while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tvalid_r <= 1'b0;
      tdata_r  <= {(NUM_CH*W){1'b0}};
      wrap_r   <= {NUM_CH{1'b0}};
    end else if (adv_s) begin
      tvalid_r <= 1'b1;
      tdata_r  <= tdata_d_s;
      wrap_r   <= wrap_s;
    end else if (m.m_tready) begin
      tvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_sweep_gen.sv
// Scoreboard bench: two instances (DIV=1 and DIV=4). Stimulus pushes the
// hand-computed samples into per-instance queues; monitors pop and compare
// on every accepted transfer. Cycle-level behaviour (reset, stall stability,
// divider pacing) is checked directly by the stimulus process.
// The wrap flag travels with the sample whose advance performed the wrap.
module tb_phase_sweep_gen;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  wrap;
  } exp_t;

  logic               clk;
  logic               rst1, rst4, en1, en4;
  logic               cfg_we, cfg_sel;
  logic [1:0]         cfg_ch;
  logic signed [15:0] cfg_data;
  int                 checks = 0;
  int                 errors = 0;
  exp_t               q1[$];
  exp_t               q4[$];
  exp_t               e1, e4;

  phase_sweep_gen_if #(.NUM_CH(2), .W(16)) s1 ();
  phase_sweep_gen_if #(.NUM_CH(2), .W(16)) s4 ();

  phase_sweep_gen #(.NUM_CH(2), .W(16), .PI_POS(16'sh6488), .DIV(1), .CHW(2)) dut1 (
    .CLK(clk), .RST(rst1), .en(en1), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_ch(cfg_ch), .cfg_data(cfg_data), .m(s1)
  );

  phase_sweep_gen #(.NUM_CH(2), .W(16), .PI_POS(16'sh6488), .DIV(4), .CHW(2)) dut4 (
    .CLK(clk), .RST(rst4), .en(en4), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_ch(cfg_ch), .cfg_data(cfg_data), .m(s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] ch, input logic signed [15:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push1(input int d0, input int d1, input logic [1:0] w);
    exp_t e;
    e.data = {16'(d1), 16'(d0)};
    e.wrap = w;
    q1.push_back(e);
  endtask

  task automatic push4(input int d0, input int d1, input logic [1:0] w);
    exp_t e;
    e.data = {16'(d1), 16'(d0)};
    e.wrap = w;
    q4.push_back(e);
  endtask

  // Monitor for the DIV=1 instance.
  always @(negedge clk) begin
    if (s1.m_tvalid && s1.m_tready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_extra: got data %h wrap %b, required no sample", s1.m_tdata, s1.m_wrap);
      end else begin
        e1 = q1.pop_front();
        if ({s1.m_tdata, s1.m_wrap} !== {e1.data, e1.wrap}) begin
          errors++;
          $display("FAIL dut1_sample: got data %h wrap %b, required data %h wrap %b",
                   s1.m_tdata, s1.m_wrap, e1.data, e1.wrap);
        end
      end
    end
  end

  // Monitor for the DIV=4 instance.
  always @(negedge clk) begin
    if (s4.m_tvalid && s4.m_tready) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL dut4_extra: got data %h wrap %b, required no sample", s4.m_tdata, s4.m_wrap);
      end else begin
        e4 = q4.pop_front();
        if ({s4.m_tdata, s4.m_wrap} !== {e4.data, e4.wrap}) begin
          errors++;
          $display("FAIL dut4_sample: got data %h wrap %b, required data %h wrap %b",
                   s4.m_tdata, s4.m_wrap, e4.data, e4.wrap);
        end
      end
    end
  end

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; en1 = 1'b0; en4 = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 16'sd0;
    s1.m_tready = 1'b1; s4.m_tready = 1'b1;
    step(2);
    @(negedge clk);
    check("rst_valid1", {33'd0, s1.m_tvalid}, 34'd0);
    check("rst_data1",  {2'b00, s1.m_tdata}, 34'd0);
    check("rst_wrap1",  {32'd0, s1.m_wrap}, 34'd0);
    check("rst_valid4", {33'd0, s4.m_tvalid}, 34'd0);
    rst1 = 1'b0;
    step(1);

    // ch0 ramps by 200 and wraps from 25600 (sum 25800) to -25672.
    for (int j = 0; j < 130; j++)
      push1((j <= 128) ? 200 * j : -25672, 0, (j == 128) ? 2'b01 : 2'b00);
    cfg_write(1'b0, 2'd0, 16'sd200);
    en1 = 1'b1; step(130); en1 = 1'b0; step(3);

    // Positive and negative wraps; exactly +pi does not wrap.
    push1(-24000,  22736, 2'b01);
    push1( 24472,  25736, 2'b10);
    push1( 21472, -22736, 2'b00);
    cfg_write(1'b0, 2'd0, -16'sd3000);
    cfg_write(1'b1, 2'd0, -16'sd24000);
    cfg_write(1'b0, 2'd1, 16'sd3000);
    cfg_write(1'b1, 2'd1, 16'sd22736);
    en1 = 1'b1; step(3); en1 = 1'b0; step(3);

    // Backpressure: first sample held for 5 cycles, then the run continues.
    push1(18472, -19736, 2'b00);
    push1(15472, -16736, 2'b00);
    push1(12472, -13736, 2'b00);
    push1( 9472, -10736, 2'b00);
    push1( 6472,  -7736, 2'b00);
    s1.m_tready = 1'b0; en1 = 1'b1;
    step(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", {33'd0, s1.m_tvalid}, 34'd1);
      check("stall_data", {2'b00, s1.m_tdata}, {2'b00, 16'hB2E8, 16'h4828});
      step(1);
    end
    s1.m_tready = 1'b1;
    step(4); en1 = 1'b0; step(3);

    // Clamped writes (inc 0x7FFF -> 0x6488, phase 0x8000 -> 0x9B78),
    // ignored out-of-range channel, and +/-pi boundary sums.
    push1(-25736, -4736, 2'b00);
    push1(     0, -1736, 2'b00);
    push1( 25736,  1264, 2'b01);
    cfg_write(1'b0, 2'd0, 16'sh7FFF);
    cfg_write(1'b1, 2'd0, 16'sh8000);
    cfg_write(1'b1, 2'd3, 16'sd1234);
    cfg_write(1'b0, 2'd3, 16'sd777);
    en1 = 1'b1; step(3); en1 = 1'b0; step(3);

    // Phase write during an advance, then increment write during an advance.
    push1(     0,  4264, 2'b00);
    push1( 25736,  7264, 2'b00);
    push1(  1000, 10264, 2'b01);
    push1(-24736, 13264, 2'b00);
    en1 = 1'b1;
    step(1);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_ch = 2'd0; cfg_data = 16'sd1000;
    step(1);
    cfg_sel = 1'b0; cfg_ch = 2'd1; cfg_data = 16'sd0;
    step(1);
    cfg_we = 1'b0;
    step(1);
    en1 = 1'b0; step(3);

    // DIV=4 pacing: a sample every 4 enabled cycles, then reset mid-stream.
    rst4 = 1'b0; step(1);
    push4(  0, 0, 2'b00);
    push4(100, 0, 2'b00);
    cfg_write(1'b0, 2'd0, 16'sd100);
    en4 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (c == 12) begin
        s4.m_tready = 1'b0;
        rst4 = 1'b1;
      end
      @(negedge clk);
      check("div4_valid", {33'd0, s4.m_tvalid}, {33'd0, (c % 4 == 0)});
    end
    check("div4_third", {2'b00, s4.m_tdata}, {2'b00, 16'd0, 16'd200});
    step(1);
    @(negedge clk);
    check("rst_mid_valid", {33'd0, s4.m_tvalid}, 34'd0);
    check("rst_mid_data", {2'b00, s4.m_tdata}, 34'd0);
    rst4 = 1'b0; en4 = 1'b0; s4.m_tready = 1'b1;
    step(1);

    // Re-enable with a pause mid-interval; increments were cleared by reset.
    push4(0, 0, 2'b00);
    push4(0, 0, 2'b00);
    en4 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1); @(negedge clk);
      check("pause_pre", {33'd0, s4.m_tvalid}, 34'd0);
    end
    en4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1); @(negedge clk);
      check("pause_hold", {33'd0, s4.m_tvalid}, 34'd0);
    end
    en4 = 1'b1;
    step(1); @(negedge clk);
    check("pause_resume0", {33'd0, s4.m_tvalid}, 34'd0);
    step(1); @(negedge clk);
    check("pause_resume1", {33'd0, s4.m_tvalid}, 34'd1);
    for (int c = 1; c <= 4; c++) begin
      step(1); @(negedge clk);
      check("redo_valid", {33'd0, s4.m_tvalid}, {33'd0, (c % 4 == 0)});
    end
    en4 = 1'b0;
    step(5);

    check("q1_drained", 34'(q1.size()), 34'd0);
    check("q4_drained", 34'(q4.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
